// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking lane arbiter.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    WAIT  = 2'b10,
    HOLD  = 2'b11
  } arb_state_e;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  function automatic int unsigned occ_width(input int unsigned capacity);
    return $clog2(capacity + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          found
);

  localparam logic [PW:0] NL = (PW+1)'(N);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      // ptr < N and i < N, so a single subtraction completes the modulo
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= NL) sum = sum - NL;
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_lane_arbiter.sv
// Round-robin lane arbiter for a shared gate controller with occupancy tracking.
// Define EXIT_PRIORITY_EN to serve eligible exit lanes ahead of entry lanes.
module parking_lane_arbiter
  import parking_pkg::*;
#(
  parameter int unsigned N_LANES     = 4,
  parameter int unsigned CAPACITY    = 100,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned CW         = occ_width(CAPACITY)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_LANES-1:0] lane_req,
  input  logic [N_LANES-1:0] lane_dir,
  output logic [N_LANES-1:0] grant,
  output logic               grant_valid,
  output logic               grant_dir,
  input  logic               svc_ack,
  input  logic               svc_done,
  input  logic               svc_fail,
  output logic [CW-1:0]      occupancy,
  output logic               full,
  output logic               empty,
  output logic               timeout_err,
  output logic [1:0]         arb_state
);

  localparam int unsigned PW   = $clog2(N_LANES);
  localparam int unsigned TW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CAP  = CW'(CAPACITY);
  localparam logic [PW-1:0] LAST = PW'(N_LANES - 1);

  arb_state_e         state_q, state_d;
  logic [N_LANES-1:0] grant_q, grant_d;
  logic               dir_q, dir_d;
  logic [PW-1:0]      idx_q, idx_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      occ_q, occ_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               tout_q, tout_d;

  logic [N_LANES-1:0] eligible;
  logic [N_LANES-1:0] win;
  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      ptr_next;

  assign full     = (occ_q == CAP);
  assign empty    = (occ_q == '0);
  assign eligible = lane_req & ((lane_dir & {N_LANES{~empty}}) | (~lane_dir & {N_LANES{~full}}));

`ifdef EXIT_PRIORITY_EN
  logic [N_LANES-1:0] exit_gnt, all_gnt;
  logic               exit_found, all_found;

  rr_arbiter #(.N(N_LANES)) u_exit_arb (
    .req   (eligible & lane_dir),
    .ptr   (ptr_q),
    .gnt   (exit_gnt),
    .found (exit_found)
  );

  rr_arbiter #(.N(N_LANES)) u_all_arb (
    .req   (eligible),
    .ptr   (ptr_q),
    .gnt   (all_gnt),
    .found (all_found)
  );

  assign win       = exit_found ? exit_gnt : all_gnt;
  assign win_found = all_found;
`else
  rr_arbiter #(.N(N_LANES)) u_arb (
    .req   (eligible),
    .ptr   (ptr_q),
    .gnt   (win),
    .found (win_found)
  );
`endif

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (win[i]) win_idx = PW'(i);
    end
  end

  assign ptr_next = (idx_q == LAST) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    occ_d   = occ_q;
    timer_d = timer_q;
    tout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          grant_d = win;
          idx_d   = win_idx;
          dir_d   = lane_dir[win_idx];
          timer_d = '0;
        end
      end
      GRANT: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TMAX) begin
          state_d = HOLD;
          tout_d  = 1'b1;
          ptr_d   = ptr_next;
        end else if (svc_ack) begin
          state_d = WAIT;
        end else if (!lane_req[idx_q]) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (svc_done) begin
          state_d = HOLD;
          ptr_d   = ptr_next;
          // Saturating update: an out-of-range change is dropped
          if (dir_q == DIR_ENTRY) begin
            if (occ_q != CAP) occ_d = occ_q + 1'b1;
          end else if (occ_q != '0) begin
            occ_d = occ_q - 1'b1;
          end
        end else if (svc_fail) begin
          state_d = HOLD;
          ptr_d   = ptr_next;
        end else if (timer_q == TMAX) begin
          state_d = HOLD;
          tout_d  = 1'b1;
          ptr_d   = ptr_next;
        end
      end
      HOLD: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      dir_q   <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
      occ_q   <= '0;
      timer_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      occ_q   <= occ_d;
      timer_q <= timer_d;
      tout_q  <= tout_d;
    end
  end

  assign grant_valid = (state_q == GRANT) || (state_q == WAIT);
  assign grant       = grant_valid ? grant_q : '0;
  assign grant_dir   = grant_valid & dir_q;
  assign occupancy   = occ_q;
  assign timeout_err = tout_q;
  assign arb_state   = state_q;

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Directed bench for parking_lane_arbiter with a grant scoreboard queue.
module tb_parking_lane_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] lane_req, lane_dir;
  logic [3:0] grant;
  logic       grant_valid, grant_dir;
  logic       svc_ack, svc_done, svc_fail;
  logic [1:0] occupancy;
  logic       full, empty, timeout_err;
  logic [1:0] arb_state;

  logic [3:0] exp_q[$];
  logic [3:0] rr_seq [3] = '{4'b0001, 4'b0100, 4'b0001};
  int checks = 0;
  int errors = 0;

  parking_lane_arbiter #(
    .N_LANES     (4),
    .CAPACITY    (3),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .lane_req    (lane_req),
    .lane_dir    (lane_dir),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_dir   (grant_dir),
    .svc_ack     (svc_ack),
    .svc_done    (svc_done),
    .svc_fail    (svc_fail),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty),
    .timeout_err (timeout_err),
    .arb_state   (arb_state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the next expected grant and compares once grant_valid rises (bounded).
  task automatic wait_grant(input string tag);
    logic [3:0] exp;
    int n;
    exp = exp_q.pop_front();
    n = 0;
    while (grant_valid !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    check(tag, 32'(grant), 32'(exp));
  endtask

  task automatic serve(input logic d, input logic f, input logic [3:0] req_after);
    svc_ack = 1'b1;
    step(1);
    svc_ack = 1'b0;
    check("in_wait", 32'(arb_state), 2);
    svc_done = d;
    svc_fail = f;
    lane_req = req_after;
    step(1);
    svc_done = 1'b0;
    svc_fail = 1'b0;
    check("in_hold", 32'(arb_state), 3);
    check("hold_gap", 32'(grant_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rstn = 1'b1;
    lane_req = '0;
    lane_dir = '0;
    svc_ack = 1'b0;
    svc_done = 1'b0;
    svc_fail = 1'b0;
    step(2);
    rstn = 1'b0;

    check("rst_state", 32'(arb_state), 0);
    check("rst_valid", 32'(grant_valid), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_tout", 32'(timeout_err), 0);

    // Exit request while empty, plus a stray svc_done in IDLE
    lane_req = 4'b0010;
    lane_dir = 4'b0010;
    svc_done = 1'b1;
    seen = 0;
    repeat (20) begin
      step(1);
      svc_done = 1'b0;
      if (grant_valid) seen++;
    end
    check("no_exit_when_empty", 32'(seen), 0);
    check("stray_done_ignored", 32'(occupancy), 0);
    lane_req = '0;
    lane_dir = '0;

    // Entry lanes 0 and 2 alternate until full
    lane_req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(rr_seq[k]);
      wait_grant("rr_entry");
      check("rr_dir", 32'(grant_dir), 0);
      serve(1'b1, 1'b0, 4'b0101);
      check("rr_occ", 32'(occupancy), 32'(k + 1));
    end
    check("full_flag", 32'(full), 1);
    seen = 0;
    repeat (10) begin
      step(1);
      if (grant_valid) seen++;
    end
    check("no_entry_when_full", 32'(seen), 0);
    lane_req = '0;

    // Exit on lane 1 (pointer is 1 after lane 0)
    lane_req = 4'b0010;
    lane_dir = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant("exit_grant");
    check("exit_dir", 32'(grant_dir), 1);
    serve(1'b1, 1'b0, 4'b0000);
    check("exit_occ", 32'(occupancy), 2);

    // Lane 3 entry with done and fail together
    lane_req = 4'b1000;
    lane_dir = 4'b0000;
    exp_q.push_back(4'b1000);
    wait_grant("l3_grant");
    serve(1'b1, 1'b1, 4'b0000);
    check("done_wins_occ", 32'(occupancy), 3);
    lane_req = 4'b1111;
    lane_dir = 4'b1111;
    exp_q.push_back(4'b0001);
    wait_grant("ptr_wrap");
    serve(1'b1, 1'b0, 4'b0000);
    check("wrap_exit_occ", 32'(occupancy), 2);

    // Timeout on lane 1 after ack
    lane_req = 4'b0010;
    lane_dir = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant("to_grant");
    svc_ack = 1'b1;
    lane_req = '0;
    step(1);
    svc_ack = 1'b0;
    step(14);
    check("to_early", 32'(timeout_err), 0);
    check("to_early_state", 32'(arb_state), 2);
    step(1);
    check("to_pulse", 32'(timeout_err), 1);
    check("to_hold", 32'(arb_state), 3);
    check("to_occ", 32'(occupancy), 2);
    step(1);
    check("to_pulse_end", 32'(timeout_err), 0);
    check("to_idle", 32'(arb_state), 0);

    // Lane 2 drops before ack; pointer must stay at 2
    lane_req = 4'b0100;
    lane_dir = 4'b0000;
    exp_q.push_back(4'b0100);
    wait_grant("drop_grant");
    lane_req = '0;
    step(1);
    check("drop_idle", 32'(arb_state), 0);
    check("drop_valid", 32'(grant_valid), 0);
    lane_req = 4'b1100;
    exp_q.push_back(4'b0100);
    wait_grant("regrant_ptr");
    serve(1'b0, 1'b1, 4'b0000);
    check("fail_occ", 32'(occupancy), 2);

    // Move pointer to 0 via a failed lane 3 transaction
    lane_req = 4'b1000;
    exp_q.push_back(4'b1000);
    wait_grant("l3_fail_grant");
    serve(1'b0, 1'b1, 4'b0000);

    // Simultaneous lane 0 entry and lane 3 exit
    lane_req = 4'b1001;
    lane_dir = 4'b1000;
`ifdef EXIT_PRIORITY_EN
    exp_q.push_back(4'b1000);
`else
    exp_q.push_back(4'b0001);
`endif
    wait_grant("exit_prio");

    // Reset mid-transaction
    svc_ack = 1'b1;
    step(1);
    svc_ack = 1'b0;
    rstn = 1'b1;
    lane_req = '0;
    step(1);
    rstn = 1'b0;
    check("mid_rst_state", 32'(arb_state), 0);
    check("mid_rst_valid", 32'(grant_valid), 0);
    check("mid_rst_occ", 32'(occupancy), 0);
    check("mid_rst_tout", 32'(timeout_err), 0);
    step(2);
    check("post_rst_tout", 32'(timeout_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
